// File: rtl/chaos_pkg.sv
// chaos_pkg
// Shared definitions for the 4-D hyperchaotic key generator:
//   - fixed-point and coefficient constants
//   - FSM state encoding
//   - sat32:      clamp a 40-bit intermediate to signed 32 bits
//   - seed_place: map a signed seed byte b to Q8.24 as b/16
//   - cmul:       multiply by a small positive constant with shifts and adds
package chaos_pkg;

    localparam int Q_FRAC = 24;
    localparam int COEF_A = 10;
    localparam int COEF_B = 3;
    localparam int COEF_C = 28;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MXZ,
        ST_MXY,
        ST_MYZ,
        ST_UPD,
        ST_FIN
    } chaos_state_t;

    function automatic logic signed [31:0] sat32(input logic signed [39:0] v);
        if (v[39:31] == {9{v[39]}})
            return v[31:0];
        else if (v[39])
            return 32'sh8000_0000;
        else
            return 32'sh7FFF_FFFF;
    endfunction

    // The seed byte lands on bits [27:20], which gives it the value b/16.
    function automatic logic signed [31:0] seed_place(input logic [7:0] b);
        return {{4{b[7]}}, b, 20'd0};
    endfunction

    // The constant is fixed at elaboration, so the loop collapses to a few adders.
    function automatic logic signed [39:0] cmul(input logic signed [39:0] v, input int c);
        logic signed [39:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++)
            if (c[i])
                acc = acc + (v <<< i);
        return acc;
    endfunction

endpackage

// File: rtl/chaos_code_gen_if.sv
// chaos_code_gen_if
// The chaos PIO bundle between the Nios software side (master) and the
// generator fabric (slave).
//   chaos_step   software step request, rising edge triggers
//   chaos_reset  software re-seed, level-sensitive
//   chaos_shift  seed bytes x,y,z,w in [31:24],[23:16],[15:8],[7:0]
//   chaos_done   result valid level
//   chaos_x..w   key bytes
interface chaos_code_gen_if;
    logic        chaos_step;
    logic        chaos_reset;
    logic [31:0] chaos_shift;
    logic        chaos_done;
    logic [7:0]  chaos_x;
    logic [7:0]  chaos_y;
    logic [7:0]  chaos_z;
    logic [7:0]  chaos_w;

    modport master (
        output chaos_step, chaos_reset, chaos_shift,
        input  chaos_done, chaos_x, chaos_y, chaos_z, chaos_w
    );

    modport slave (
        input  chaos_step, chaos_reset, chaos_shift,
        output chaos_done, chaos_x, chaos_y, chaos_z, chaos_w
    );
endinterface

// File: rtl/chaos_sat_mul.sv
// chaos_sat_mul
// Combinational signed Q8.24 x Q8.24 multiply with saturation.
//   a, b  signed Q8.24 operands
//   p     signed Q8.24 product, clamped to 0x7FFFFFFF / 0x80000000
module chaos_sat_mul
    import chaos_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] p
);

    logic signed [63:0] prod_sh;

    // After the arithmetic shift, bits [63:31] all equal is the same test
    // as bits [63:55] all equal on the raw 64-bit product.
    always_comb begin
        prod_sh = (64'(a) * 64'(b)) >>> Q_FRAC;
        if (prod_sh[63:31] == {33{prod_sh[63]}})
            p = prod_sh[31:0];
        else if (prod_sh[63])
            p = 32'sh8000_0000;
        else
            p = 32'sh7FFF_FFFF;
    end

endmodule

// File: rtl/chaos_code_gen.sv
// chaos_code_gen
// Fixed-point 4-D hyperchaotic keystream generator. Each accepted step runs
// ITERS forward-Euler iterations (step size 2^-H), then latches bits [23:16]
// of each state variable as a key byte.
//   clk_clk      system clock
//   reset_reset  asynchronous active-high reset
//   bus          chaos PIO bundle (slave side)
module chaos_code_gen
    import chaos_pkg::*;
#(
    parameter int ITERS = 16,
    parameter int H     = 8
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    chaos_code_gen_if.slave  bus
);

    localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;

    chaos_state_t       state;
    logic               step_q;
    logic               done;
    logic [IW-1:0]      iter;
    logic signed [31:0] x, y, z, w;
    logic signed [31:0] p_xz, p_xy, p_yz;
    logic [7:0]         key_x, key_y, key_z, key_w;

    logic signed [31:0] mul_a, mul_b, mul_p;
    logic signed [39:0] xe, ye, ze, we, pxze, pxye, pyze;
    logic signed [39:0] dx, dy, dz, dw;
    logic signed [31:0] x_nx, y_nx, z_nx, w_nx;
    logic               step_edge;

    assign step_edge = bus.chaos_step & ~step_q;

    // One multiplier, operands steered by the product currently being formed.
    always_comb begin
        mul_a = y;
        mul_b = z;
        case (state)
            ST_MXZ: begin mul_a = x; mul_b = z; end
            ST_MXY: begin mul_a = x; mul_b = y; end
            default: ;
        endcase
    end

    chaos_sat_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        xe   = 40'(x);
        ye   = 40'(y);
        ze   = 40'(z);
        we   = 40'(w);
        pxze = 40'(p_xz);
        pxye = 40'(p_xy);
        pyze = 40'(p_yz);
        dx   = cmul(ye - xe, COEF_A) + we;
        dy   = cmul(xe, COEF_C) - ye - pxze;
        dz   = pxye - cmul(ze, COEF_B);
        dw   = -pyze - we;
        x_nx = sat32(xe + (dx >>> H));
        y_nx = sat32(ye + (dy >>> H));
        z_nx = sat32(ze + (dz >>> H));
        w_nx = sat32(we + (dw >>> H));
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state  <= ST_IDLE;
            step_q <= 1'b0;
            done   <= 1'b0;
            iter   <= '0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            w      <= '0;
            p_xz   <= '0;
            p_xy   <= '0;
            p_yz   <= '0;
            key_x  <= '0;
            key_y  <= '0;
            key_z  <= '0;
            key_w  <= '0;
        end else begin
            step_q <= bus.chaos_step;
            if (bus.chaos_reset) begin
                // Re-seed wins over any run in progress; key bytes keep their value.
                state <= ST_IDLE;
                done  <= 1'b0;
                x     <= seed_place(bus.chaos_shift[31:24]);
                y     <= seed_place(bus.chaos_shift[23:16]);
                z     <= seed_place(bus.chaos_shift[15:8]);
                w     <= seed_place(bus.chaos_shift[7:0]);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (step_edge) begin
                            state <= ST_MXZ;
                            done  <= 1'b0;
                            iter  <= '0;
                        end
                    end
                    ST_MXZ: begin
                        p_xz  <= mul_p;
                        state <= ST_MXY;
                    end
                    ST_MXY: begin
                        p_xy  <= mul_p;
                        state <= ST_MYZ;
                    end
                    ST_MYZ: begin
                        p_yz  <= mul_p;
                        state <= ST_UPD;
                    end
                    ST_UPD: begin
                        x     <= x_nx;
                        y     <= y_nx;
                        z     <= z_nx;
                        w     <= w_nx;
                        iter  <= iter + 1'b1;
                        state <= (iter == IW'(ITERS - 1)) ? ST_FIN : ST_MXZ;
                    end
                    ST_FIN: begin
                        key_x <= x[23:16];
                        key_y <= y[23:16];
                        key_z <= z[23:16];
                        key_w <= w[23:16];
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.chaos_done = done;
    assign bus.chaos_x    = key_x;
    assign bus.chaos_y    = key_y;
    assign bus.chaos_z    = key_z;
    assign bus.chaos_w    = key_w;

endmodule

// File: tb/tb_chaos_code_gen.sv
// tb_chaos_code_gen
// Directed bench for chaos_code_gen. dut0 uses the default parameters
// (ITERS=16, H=8); dut1 uses ITERS=1 so single iterations can be checked
// against hand-worked values. A small longint model of the system provides
// expected key bytes for the multi-iteration and saturation scenarios.
// Cycle counts are the number of rising clock edges from the one that
// samples the step edge (E0 = count 1) until chaos_done reads high.
module tb_chaos_code_gen;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -MAXV - 1;

    longint mx, my, mz, mw;

    chaos_code_gen_if bus0 ();
    chaos_code_gen_if bus1 ();

    chaos_code_gen dut0 (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus0)
    );

    chaos_code_gen #(.ITERS(1), .H(8)) dut1 (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint msat(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic longint mmul(input longint a, input longint b);
        return msat((a * b) >>> 24);
    endfunction

    function automatic longint mseed(input logic [7:0] b);
        return longint'($signed(b)) * 64'sd1048576;
    endfunction

    task automatic model_seed(input logic [31:0] s);
        mx = mseed(s[31:24]);
        my = mseed(s[23:16]);
        mz = mseed(s[15:8]);
        mw = mseed(s[7:0]);
    endtask

    task automatic model_run();
        longint pxz, pxy, pyz, dx, dy, dz, dw;
        for (int it = 0; it < 16; it++) begin
            pxz = mmul(mx, mz);
            pxy = mmul(mx, my);
            pyz = mmul(my, mz);
            dx  = 10 * (my - mx) + mw;
            dy  = 28 * mx - my - pxz;
            dz  = pxy - 3 * mz;
            dw  = -pyz - mw;
            mx  = msat(mx + (dx >>> 8));
            my  = msat(my + (dy >>> 8));
            mz  = msat(mz + (dz >>> 8));
            mw  = msat(mw + (dw >>> 8));
        end
    endtask

    function automatic logic [31:0] model_keys();
        return {mx[23:16], my[23:16], mz[23:16], mw[23:16]};
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] keys(input bit sel);
        if (sel) return {bus1.chaos_x, bus1.chaos_y, bus1.chaos_z, bus1.chaos_w};
        return {bus0.chaos_x, bus0.chaos_y, bus0.chaos_z, bus0.chaos_w};
    endfunction

    function automatic logic done_of(input bit sel);
        return sel ? bus1.chaos_done : bus0.chaos_done;
    endfunction

    task automatic load_seed(input bit sel, input logic [31:0] s);
        if (sel) begin
            bus1.chaos_shift = s;
            bus1.chaos_reset = 1'b1;
        end else begin
            bus0.chaos_shift = s;
            bus0.chaos_reset = 1'b1;
        end
        @(negedge clk);
        bus0.chaos_reset = 1'b0;
        bus1.chaos_reset = 1'b0;
    endtask

    // Raises step for one edge, returns the edge count at which done was
    // seen (-1 on timeout) and the done level right after E0.
    task automatic run_step(input bit sel, output int cyc, output logic d1);
        if (sel) bus1.chaos_step = 1'b1; else bus0.chaos_step = 1'b1;
        cyc = -1;
        d1  = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                d1 = done_of(sel);
                bus0.chaos_step = 1'b0;
                bus1.chaos_step = 1'b0;
            end
            if (done_of(sel)) begin
                cyc = i;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [32:0] obs;
        repeat (2) @(negedge clk);
        obs = {bus0.chaos_done, keys(0)};
        checks++;
        if (obs !== 33'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, 33'd0);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_origin();
        int cyc;
        logic d1;
        load_seed(0, 32'h0000_0000);
        run_step(0, cyc, d1);
        checks++;
        if (cyc !== 66) begin
            errors++;
            $display("FAIL origin_latency: got %0d expected %0d", cyc, 66);
        end
        checks++;
        if (keys(0) !== 32'h0000_0000) begin
            errors++;
            $display("FAIL origin_keys: got %h expected %h", keys(0), 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_single_iter();
        logic [31:0] seeds [4];
        logic [31:0] exp_k [4];
        bit          reseed [4];
        int cyc;
        logic d1;
        // x=1.0 -> one iteration, then a second iteration continuing the trajectory
        seeds[0] = 32'h1000_0000; exp_k[0] = 32'hF61C_0000; reseed[0] = 1'b1;
        seeds[1] = 32'h1000_0000; exp_k[1] = 32'hED36_0000; reseed[1] = 1'b0;
        // x=-1.0
        seeds[2] = 32'hF000_0000; exp_k[2] = 32'h0AE4_0000; reseed[2] = 1'b1;
        // w=1.0
        seeds[3] = 32'h0000_0010; exp_k[3] = 32'h0100_00FF; reseed[3] = 1'b1;
        for (int v = 0; v < 4; v++) begin
            if (reseed[v]) load_seed(1, seeds[v]);
            run_step(1, cyc, d1);
            checks++;
            if (cyc !== 6) begin
                errors++;
                $display("FAIL single_latency[%0d]: got %0d expected %0d", v, cyc, 6);
            end
            checks++;
            if (keys(1) !== exp_k[v]) begin
                errors++;
                $display("FAIL single_keys[%0d]: got %h expected %h", v, keys(1), exp_k[v]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_step_filter();
        int rises, first, cyc;
        logic prev, d, d1;
        load_seed(0, 32'h1000_0000);
        model_seed(32'h1000_0000);
        model_run();
        bus0.chaos_step = 1'b1;
        rises = 0;
        first = -1;
        prev  = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            d = bus0.chaos_done;
            if (d && !prev) begin
                rises++;
                if (first < 0) first = i;
            end
            prev = d;
        end
        bus0.chaos_step = 1'b0;
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL held_step_runs: got %0d expected %0d", rises, 1);
        end
        checks++;
        if (first !== 66) begin
            errors++;
            $display("FAIL held_step_latency: got %0d expected %0d", first, 66);
        end
        checks++;
        if (keys(0) !== model_keys()) begin
            errors++;
            $display("FAIL held_step_keys: got %h expected %h", keys(0), model_keys());
        end
        @(negedge clk);

        // new run from the continued state, with a stray second edge mid-run
        model_run();
        bus0.chaos_step = 1'b1;
        cyc = -1;
        d1  = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                d1 = bus0.chaos_done;
                bus0.chaos_step = 1'b0;
            end
            if (i == 20) bus0.chaos_step = 1'b1;
            if (i == 21) bus0.chaos_step = 1'b0;
            if (bus0.chaos_done) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (d1 !== 1'b0) begin
            errors++;
            $display("FAIL done_drop_at_edge: got %b expected %b", d1, 1'b0);
        end
        checks++;
        if (cyc !== 66) begin
            errors++;
            $display("FAIL second_edge_latency: got %0d expected %0d", cyc, 66);
        end
        checks++;
        if (keys(0) !== model_keys()) begin
            errors++;
            $display("FAIL continued_keys: got %h expected %h", keys(0), model_keys());
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [31:0] k_before;
        int saw_done, cyc;
        logic d1;
        k_before = keys(0);
        bus0.chaos_shift = 32'hF000_0000;
        bus0.chaos_step  = 1'b1;
        saw_done = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1)  bus0.chaos_step  = 1'b0;
            if (i == 10) bus0.chaos_reset = 1'b1;
            if (i == 12) bus0.chaos_step  = 1'b1;
            if (i == 15) bus0.chaos_reset = 1'b0;
            if (bus0.chaos_done) saw_done++;
        end
        bus0.chaos_step = 1'b0;
        checks++;
        if (saw_done !== 0) begin
            errors++;
            $display("FAIL abort_done_cycles: got %0d expected %0d", saw_done, 0);
        end
        checks++;
        if (keys(0) !== k_before) begin
            errors++;
            $display("FAIL abort_keys_held: got %h expected %h", keys(0), k_before);
        end
        @(negedge clk);
        model_seed(32'hF000_0000);
        model_run();
        run_step(0, cyc, d1);
        checks++;
        if (keys(0) !== model_keys() || cyc !== 66) begin
            errors++;
            $display("FAIL abort_reseed_run: got %h at %0d expected %h at %0d",
                     keys(0), cyc, model_keys(), 66);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [32:0] obs;
        int cyc;
        logic d1;
        bus0.chaos_step = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) bus0.chaos_step = 1'b0;
        end
        #2 rst = 1'b1;
        #1 obs = {bus0.chaos_done, keys(0)};
        checks++;
        if (obs !== 33'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected %h", obs, 33'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_step(0, cyc, d1);
        checks++;
        if (cyc !== 66) begin
            errors++;
            $display("FAIL reset_mid_latency: got %0d expected %0d", cyc, 66);
        end
        checks++;
        if (keys(0) !== 32'h0000_0000) begin
            errors++;
            $display("FAIL reset_mid_zero_keys: got %h expected %h", keys(0), 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int cyc;
        logic d1;
        load_seed(0, 32'h7F7F_7F7F);
        model_seed(32'h7F7F_7F7F);
        for (int s = 0; s < 100; s++) begin
            model_run();
            run_step(0, cyc, d1);
            checks++;
            if (keys(0) !== model_keys() || cyc !== 66) begin
                errors++;
                $display("FAIL sat_step[%0d]: got %h at %0d expected %h at %0d",
                         s, keys(0), cyc, model_keys(), 66);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus0.chaos_step  = 1'b0;
        bus0.chaos_reset = 1'b0;
        bus0.chaos_shift = 32'h0;
        bus1.chaos_step  = 1'b0;
        bus1.chaos_reset = 1'b0;
        bus1.chaos_shift = 32'h0;
        test_reset();
        test_origin();
        test_single_iter();
        test_step_filter();
        test_abort();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
